lsu_pipe_exec_unit: RTL and testbench
=====================================

LSU_PIPE_EXEC_UNIT -- requirements
Module: lsu_pipe_exec_unit

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 32, data word width in bits (multiple of 8); ADDR_WIDTH 5, word-address bits of data RAM; TAG_WIDTH 6, CDB tag width.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; ports listed in REQ-003..REQ-019.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 issue_valid  in  1  issue queue presents an op.
REQ-006 issue_ready  out  1  unit accepts op this cycle.
REQ-007 issue_is_store  in  1  1 = store, 0 = load.
REQ-008 issue_size  in  2  0 = byte, 1 = half, 2 = word; 3 reserved, treated as word.
REQ-009 issue_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 issue_rs_data  in  DATA_WIDTH  base register.
REQ-011 issue_rt_data  in  DATA_WIDTH  store data (low bytes used).
REQ-012 issue_imm  in  DATA_WIDTH  offset.
REQ-013 issue_rd_tag  in  TAG_WIDTH  load destination tag.
REQ-014 flush  in  1  synchronous kill of in-flight loads.
REQ-015 cdb_valid  out  1  load result on CDB.
REQ-016 cdb_data  out  DATA_WIDTH  extended load data.
REQ-017 cdb_tag  out  TAG_WIDTH  tag of broadcast load.
REQ-018 cdb_exc  out  1  broadcast load was misaligned.
REQ-019 cdb_grant  in  1  arbiter takes result this cycle.

Function
REQ-020 Effective address SHALL be rs_data + imm modulo 2^DATA_WIDTH; byte offset = low log2(DATA_WIDTH/8) bits; word index = next ADDR_WIDTH bits, upper bits ignored (wrap).
REQ-021 An op SHALL be accepted at a rising edge where issue_valid and issue_ready are both 1.
REQ-022 Accepted aligned store SHALL write only the addressed byte lanes (byte-enable) at the accepting edge and produce no CDB output.
REQ-023 Misaligned access (half at odd offset, word at offset != 0): store SHALL not write; load SHALL broadcast with cdb_data 0 and cdb_exc 1.
REQ-024 Pipeline: S1 register (addr, size, unsigned, tag, valid) loaded at accept edge; RAM read synchronous; result register (data, tag, exc, valid) loaded from S1 at next edge.
REQ-025 Load latency SHALL be 2 edges: accepted at edge E0 -> cdb_valid high after E1 when result register free.
REQ-026 Result register SHALL hold contents stable until edge with cdb_valid and cdb_grant; S1 advances when result register empty or granted that cycle.
REQ-027 issue_ready = !flush and (!S1.valid or S1 advances this cycle); back-to-back loads SHALL sustain one per cycle with cdb_grant held 1.
REQ-028 While S1 stalls, RAM address SHALL be driven from S1 so read data remains valid at release.
REQ-029 Load extension: selected byte/half shifted to bit 0, then zero- or sign-extended to DATA_WIDTH per issue_unsigned.
REQ-030 flush SHALL clear S1.valid and result valid at the edge; stores already written are not undone; issue ignored that cycle.
REQ-031 Store accepted while load in S1 SHALL not alter that load's data (program order; load read precedes write).

Reset
REQ-032 While rst is 1: issue_ready 0, cdb_valid 0, cdb_data 0, cdb_tag 0, cdb_exc 0, S1 and result valid 0; RAM contents not cleared.
REQ-033 Reset asserted mid-operation SHALL discard in-flight loads; issue_ready 1 the first cycle after release.

Structure
REQ-034 Size encodings, DATA_WIDTH/ADDR_WIDTH/TAG_WIDTH defaults SHALL live in variables.sv shared package.
REQ-035 Data RAM SHALL be sub-module lsu_be_ram (synchronous read, per-byte write enable, DATA_WIDTH x 2^ADDR_WIDTH).

Verification
REQ-036 Store word 0xDEADBEEF rs=0x10 imm=4, then load word same address, grant 1 -> cdb_data 0xDEADBEEF, tag matches, 2 edges after load accept.
REQ-037 Store byte 0x80 at 0x15; load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-038 Load half at address 0x3 -> cdb_exc 1, cdb_data 0; store word at 0x2 -> RAM unchanged.
REQ-039 Three back-to-back loads, cdb_grant 0 for 3 cycles -> result held stable, issue_ready 0 after second accept, all three delivered in order after grant.
REQ-040 flush one cycle after load accept -> no cdb_valid for that load; following store still writes.
REQ-041 rst pulsed with load in S1 -> cdb_valid stays 0; previously stored data readable after reset.

Source files
------------

// File: rtl/variables.sv
// Shared LSU definitions: default widths and the access-size encoding.
package variables;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int TAG_WIDTH_DEF  = 6;

  // Encoding 3 is reserved and behaves exactly like a full-word access.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

endpackage

// File: rtl/lsu_be_ram.sv
// Data RAM: one word per address, per-byte write enables, registered read (read-before-write).
module lsu_be_ram #(
  parameter int DW = 32,
  parameter int AW = 5
)(
  input  logic             clk,
  input  logic             i_we,
  input  logic [DW/8-1:0]  i_be,
  input  logic [AW-1:0]    i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int i = 0; i < DW / 8; i++) begin
        if (i_be[i]) r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lsu_pipe_exec_unit.sv
// Load/store execution unit: address calc + store write at accept, S1 RAM read, result register onto the CDB.
module lsu_pipe_exec_unit
  import variables::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TAG_WIDTH  = TAG_WIDTH_DEF
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_is_store,
  input  logic [1:0]            issue_size,
  input  logic                  issue_unsigned,
  input  logic [DATA_WIDTH-1:0] issue_rs_data,
  input  logic [DATA_WIDTH-1:0] issue_rt_data,
  input  logic [DATA_WIDTH-1:0] issue_imm,
  input  logic [TAG_WIDTH-1:0]  issue_rd_tag,
  input  logic                  flush,
  output logic                  cdb_valid,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic                  cdb_exc,
  input  logic                  cdb_grant
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);

  logic [DATA_WIDTH-1:0] w_ea;
  logic [OW-1:0]         w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [ADDR_WIDTH-1:0] w_raddr;
  size_e                 w_size;
  logic                  w_mis;
  logic                  w_acc;
  logic                  w_we;
  logic                  w_s1_adv;
  logic                  w_unused_ea;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_load_data;

  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_idx;
  logic [OW-1:0]         r_s1_off;
  size_e                 r_s1_size;
  logic                  r_s1_unsigned;
  logic [TAG_WIDTH-1:0]  r_s1_tag;
  logic                  r_s1_exc;

  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic [TAG_WIDTH-1:0]  r_res_tag;
  logic                  r_res_exc;

  assign w_ea        = issue_rs_data + issue_imm;
  assign w_off       = w_ea[OW-1:0];
  assign w_idx       = w_ea[OW +: ADDR_WIDTH];
  assign w_unused_ea = ^w_ea[DATA_WIDTH-1:OW+ADDR_WIDTH];
  assign w_size      = size_e'(issue_size);

  assign w_s1_adv    = !r_res_valid || cdb_grant;
  assign issue_ready = !rst && !flush && (!r_s1_valid || w_s1_adv);
  assign w_acc       = issue_valid && issue_ready;
  assign w_we        = w_acc && issue_is_store && !w_mis;
  // A stalled load keeps re-reading its own word so the data is fresh when it finally moves on.
  assign w_raddr     = (r_s1_valid && !w_s1_adv) ? r_s1_idx : w_idx;

  always_comb begin
    w_mis   = 1'b0;
    w_be    = '1;
    w_wdata = issue_rt_data;
    case (w_size)
      SZ_BYTE: begin
        w_be    = {{(NB-1){1'b0}}, 1'b1} << w_off;
        w_wdata = {NB{issue_rt_data[7:0]}};
      end
      SZ_HALF: begin
        w_mis   = w_off[0];
        w_be    = {{(NB-2){1'b0}}, 2'b11} << w_off;
        w_wdata = {(NB/2){issue_rt_data[15:0]}};
      end
      default: w_mis = (w_off != '0);
    endcase
  end

  lsu_be_ram #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_waddr(w_idx),
    .i_wdata(w_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rd_data)
  );

  assign w_shift = w_rd_data >> {r_s1_off, 3'b000};

  always_comb begin
    w_load_data = w_shift;
    case (r_s1_size)
      SZ_BYTE: w_load_data = {{(DATA_WIDTH-8){!r_s1_unsigned && w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: w_load_data = {{(DATA_WIDTH-16){!r_s1_unsigned && w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
    if (r_s1_exc) w_load_data = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_idx      <= '0;
      r_s1_off      <= '0;
      r_s1_size     <= SZ_BYTE;
      r_s1_unsigned <= 1'b0;
      r_s1_tag      <= '0;
      r_s1_exc      <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_acc) begin
      r_s1_valid    <= !issue_is_store;
      r_s1_idx      <= w_idx;
      r_s1_off      <= w_off;
      r_s1_size     <= w_size;
      r_s1_unsigned <= issue_unsigned;
      r_s1_tag      <= issue_rd_tag;
      r_s1_exc      <= w_mis;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_exc   <= 1'b0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_data <= w_load_data;
        r_res_tag  <= r_s1_tag;
        r_res_exc  <= r_s1_exc;
      end
    end
  end

  assign cdb_valid = r_res_valid;
  assign cdb_data  = r_res_data;
  assign cdb_tag   = r_res_tag;
  assign cdb_exc   = r_res_exc;

endmodule

// File: tb/tb_lsu_pipe_exec_unit.sv
// Directed bench for lsu_pipe_exec_unit: vector table plus stall, flush, ordering and reset sequences.
module tb_lsu_pipe_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_is_store;
  logic [1:0]  issue_size;
  logic        issue_unsigned;
  logic [31:0] issue_rs_data;
  logic [31:0] issue_rt_data;
  logic [31:0] issue_imm;
  logic [5:0]  issue_rd_tag;
  logic        flush;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_tag;
  logic        cdb_exc;
  logic        cdb_grant;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [5:0]  tag;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[16];

  lsu_pipe_exec_unit dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_is_store(issue_is_store),
    .issue_size    (issue_size),
    .issue_unsigned(issue_unsigned),
    .issue_rs_data (issue_rs_data),
    .issue_rt_data (issue_rt_data),
    .issue_imm     (issue_imm),
    .issue_rd_tag  (issue_rd_tag),
    .flush         (flush),
    .cdb_valid     (cdb_valid),
    .cdb_data      (cdb_data),
    .cdb_tag       (cdb_tag),
    .cdb_exc       (cdb_exc),
    .cdb_grant     (cdb_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic uns,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                              input logic [5:0] tag, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.st = st; v.sz = sz; v.uns = uns; v.rs = rs; v.rt = rt; v.imm = imm;
    v.tag = tag; v.exp_data = ed; v.exp_exc = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_is_store = v.st;
    issue_size     = v.sz;
    issue_unsigned = v.uns;
    issue_rs_data  = v.rs;
    issue_rt_data  = v.rt;
    issue_imm      = v.imm;
    issue_rd_tag   = v.tag;
    issue_valid    = 1'b1;
  endtask

  // Presents an op from a negedge; returns 1 time unit after the accepting edge.
  task automatic do_issue(input vec_t v);
    int n;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!issue_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: issue_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input vec_t v);
    do_issue(v);
    if (v.st) begin
      @(posedge clk);
      #1;
      chk({name, "_store_no_cdb"}, 32'(cdb_valid), 32'd0);
      $display("%s: store sz=%0d ea=%h data=%h", name, v.sz, v.rs + v.imm, v.rt);
    end else begin
      chk({name, "_lat1_valid"}, 32'(cdb_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_valid"}, 32'(cdb_valid), 32'd1);
      chk({name, "_data"}, cdb_data, v.exp_data);
      chk({name, "_tag"}, 32'(cdb_tag), 32'(v.tag));
      chk({name, "_exc"}, 32'(cdb_exc), 32'(v.exp_exc));
      $display("%s: load sz=%0d ea=%h -> data=%h tag=%0d exc=%0d", name, v.sz, v.rs + v.imm,
               cdb_data, cdb_tag, cdb_exc);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 2, 0, 32'h10,  32'hDEADBEEF, 32'h4,        6'd0,  32'h0,        0);
    vecs[1]  = mk(0, 2, 0, 32'h10,  32'h0,        32'h4,        6'h2A, 32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 0, 0, 32'h15,  32'h80,       32'h0,        6'd0,  32'h0,        0);
    vecs[3]  = mk(0, 0, 0, 32'h15,  32'h0,        32'h0,        6'd3,  32'hFFFFFF80, 0);
    vecs[4]  = mk(0, 0, 1, 32'h15,  32'h0,        32'h0,        6'd4,  32'h00000080, 0);
    vecs[5]  = mk(0, 1, 0, 32'h14,  32'h0,        32'h2,        6'd5,  32'hFFFFDEAD, 0);
    vecs[6]  = mk(0, 1, 1, 32'h14,  32'h0,        32'h0,        6'd6,  32'h000080EF, 0);
    vecs[7]  = mk(1, 2, 0, 32'h380, 32'h11223344, 32'hFFFFFC80, 6'd0,  32'h0,        0);
    vecs[8]  = mk(0, 1, 0, 32'h3,   32'h0,        32'h0,        6'd7,  32'h0,        1);
    vecs[9]  = mk(1, 2, 0, 32'h2,   32'hCAFEF00D, 32'h0,        6'd0,  32'h0,        0);
    vecs[10] = mk(0, 2, 0, 32'h80,  32'h0,        32'h0,        6'd8,  32'h11223344, 0);
    vecs[11] = mk(0, 2, 0, 32'h1,   32'h0,        32'h0,        6'd9,  32'h0,        1);
    vecs[12] = mk(1, 1, 0, 32'h2,   32'h5555ABCD, 32'h0,        6'd0,  32'h0,        0);
    vecs[13] = mk(0, 2, 0, 32'h0,   32'h0,        32'h0,        6'd10, 32'hABCD3344, 0);
    vecs[14] = mk(0, 3, 0, 32'h0,   32'h0,        32'h0,        6'd12, 32'hABCD3344, 0);
    vecs[15] = mk(0, 0, 0, 32'h3,   32'h0,        32'h0,        6'd13, 32'hFFFFFFAB, 0);

    rst = 1'b1;
    flush = 1'b0;
    cdb_grant = 1'b1;
    issue_valid = 1'b0;
    issue_is_store = 1'b0;
    issue_size = 2'd0;
    issue_unsigned = 1'b0;
    issue_rs_data = '0;
    issue_rt_data = '0;
    issue_imm = '0;
    issue_rd_tag = '0;

    #12;
    chk("rst_ready", 32'(issue_ready), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_exc", 32'(cdb_exc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(issue_ready), 32'd1);
    $display("reset: checked idle outputs");

    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Three loads against a stalled CDB, then released in order.
    run_op("bb_st0", mk(1, 2, 0, 32'h20, 32'hA0A00001, 32'h0, 6'd0, 32'h0, 0));
    run_op("bb_st1", mk(1, 2, 0, 32'h24, 32'hA0A00002, 32'h0, 6'd0, 32'h0, 0));
    run_op("bb_st2", mk(1, 2, 0, 32'h28, 32'hA0A00003, 32'h0, 6'd0, 32'h0, 0));
    @(negedge clk);
    cdb_grant = 1'b0;
    do_issue(mk(0, 2, 0, 32'h20, 32'h0, 32'h0, 6'd11, 32'h0, 0));
    do_issue(mk(0, 2, 0, 32'h24, 32'h0, 32'h0, 6'd12, 32'h0, 0));
    chk("bb_ready_after_2", 32'(issue_ready), 32'd0);
    chk("bb_first_valid", 32'(cdb_valid), 32'd1);
    drive(mk(0, 2, 0, 32'h28, 32'h0, 32'h0, 6'd13, 32'h0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bb_hold%0d_data", i), cdb_data, 32'hA0A00001);
      chk($sformatf("bb_hold%0d_tag", i), 32'(cdb_tag), 32'd11);
      chk($sformatf("bb_hold%0d_ready", i), 32'(issue_ready), 32'd0);
    end
    cdb_grant = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    chk("bb_second_tag", 32'(cdb_tag), 32'd12);
    chk("bb_second_data", cdb_data, 32'hA0A00002);
    @(posedge clk);
    #1;
    chk("bb_third_tag", 32'(cdb_tag), 32'd13);
    chk("bb_third_data", cdb_data, 32'hA0A00003);
    @(posedge clk);
    #1;
    chk("bb_drained", 32'(cdb_valid), 32'd0);
    $display("backtoback: three loads delivered after stall");

    // Flush kills the in-flight load and ignores the op presented with it.
    run_op("fl_st", mk(1, 2, 0, 32'h44, 32'h0BADF00D, 32'h0, 6'd0, 32'h0, 0));
    do_issue(mk(0, 2, 0, 32'h14, 32'h0, 32'h0, 6'd20, 32'h0, 0));
    flush = 1'b1;
    drive(mk(1, 2, 0, 32'h44, 32'hFFFFFFFF, 32'h0, 6'd0, 32'h0, 0));
    #1;
    chk("fl_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fl_no_cdb0", 32'(cdb_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("fl_no_cdb1", 32'(cdb_valid), 32'd0);
    $display("flush: in-flight load dropped");
    run_op("fl_ignored", mk(0, 2, 0, 32'h44, 32'h0, 32'h0, 6'd22, 32'h0BADF00D, 0));
    run_op("fl_st2", mk(1, 2, 0, 32'h40, 32'h12345678, 32'h0, 6'd0, 32'h0, 0));
    run_op("fl_ld2", mk(0, 2, 0, 32'h40, 32'h0, 32'h0, 6'd23, 32'h12345678, 0));

    // Store right behind a load to the same word must not leak into the load.
    do_issue(mk(0, 2, 0, 32'h40, 32'h0, 32'h0, 6'd21, 32'h0, 0));
    do_issue(mk(1, 2, 0, 32'h40, 32'h99999999, 32'h0, 6'd0, 32'h0, 0));
    chk("ord_valid", 32'(cdb_valid), 32'd1);
    chk("ord_data", cdb_data, 32'h12345678);
    chk("ord_tag", 32'(cdb_tag), 32'd21);
    $display("order: load kept pre-store data %h", cdb_data);
    run_op("ord_after", mk(0, 2, 0, 32'h40, 32'h0, 32'h0, 6'd24, 32'h99999999, 0));

    // Reset with a load in S1.
    do_issue(mk(0, 2, 0, 32'h14, 32'h0, 32'h0, 6'd30, 32'h0, 0));
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("mrst_ready", 32'(issue_ready), 32'd0);
    chk("mrst_tag", 32'(cdb_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_quiet%0d", i), 32'(cdb_valid), 32'd0);
    end
    $display("midreset: in-flight load discarded");
    run_op("mrst_ld", mk(0, 2, 0, 32'h14, 32'h0, 32'h0, 6'd31, 32'hDEAD80EF, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
